dmem_access_ctrl: RTL

- Sequences every load/store in the MEM stage against a variable-latency data memory using a req/ack handshake.
- Drives a stall that freezes the IF/ID, ID/EX and EX/MEM pipeline registers while an access is outstanding.
- Drives a flush that inserts a bubble into MEM/WB while the pipeline is stalled.
- Sits between the EX/MEM register outputs and the data memory. Returns load data to the writeback mux.

---
 rtl/dmem_access_ctrl.sv | 136 +++++++++++++
 1 files changed

// File: rtl/dmem_access_ctrl.sv
// MEM-stage data memory access sequencer: req/ack handshake with timeout,
// pipeline stall/flush generation and a saturating stall-cycle counter.
module dmem_access_ctrl #(
   parameter int unsigned TIMEOUT  = 16,
   parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF,
   parameter int unsigned CW       = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          MemWriteM,
   input  logic [1:0]    ResultSrcM,
   input  logic [31:0]   ALUResultM,
   input  logic [31:0]   WriteDataM,
   output logic          mem_req,
   output logic          mem_we,
   output logic [31:0]   mem_addr,
   output logic [31:0]   mem_wdata,
   input  logic          mem_ack,
   input  logic [31:0]   mem_rdata,
   output logic [31:0]   ReadDataM,
   output logic          StallM,
   output logic          FlushW,
   output logic          misalign,
   output logic          timeout,
   output logic [CW-1:0] StallCount
);

   localparam int unsigned WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t        state_q, state_d;
   logic          req_q, req_d;
   logic          we_q, we_d;
   logic [31:0]   addr_q, addr_d;
   logic [31:0]   wdata_q, wdata_d;
   logic [31:0]   rdata_q, rdata_d;
   logic [WW-1:0] wait_q, wait_d;
   logic          mis_q, mis_d;
   logic          to_q, to_d;
   logic [CW-1:0] cnt_q, cnt_d;

   logic access, aligned, start, expire;

   assign access  = MemWriteM | (ResultSrcM == 2'b01);
   assign aligned = (ALUResultM[1:0] == 2'b00);
   assign start   = (state_q == IDLE) && access && aligned;
   // An ack in the final wait cycle takes priority over abandoning the access.
   assign expire  = (state_q == BUSY) && !mem_ack && (wait_q == WW'(TIMEOUT - 1));

   always_ff @(posedge clk) begin
      if (!rst) state_q <= IDLE;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = BUSY;
         BUSY:    if (mem_ack || expire) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      StallM = start || (state_q == BUSY);
      FlushW = StallM;
   end

   always_comb begin
      req_d   = req_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      wait_d  = wait_q;
      mis_d   = (state_q == IDLE) && access && !aligned;
      to_d    = 1'b0;
      cnt_d   = cnt_q;
      if (start) begin
         req_d   = 1'b1;
         we_d    = MemWriteM;
         addr_d  = ALUResultM;
         wdata_d = WriteDataM;
         wait_d  = '0;
      end
      if (state_q == BUSY) begin
         if (mem_ack) begin
            req_d = 1'b0;
            if (!we_q) rdata_d = mem_rdata;
         end else if (expire) begin
            req_d = 1'b0;
            to_d  = 1'b1;
            if (!we_q) rdata_d = ERR_DATA;
         end else begin
            wait_d = wait_q + 1'b1;
         end
      end
      if (StallM && (cnt_q != {CW{1'b1}})) cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         req_q   <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         wait_q  <= '0;
         mis_q   <= 1'b0;
         to_q    <= 1'b0;
         cnt_q   <= '0;
      end else begin
         req_q   <= req_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         wait_q  <= wait_d;
         mis_q   <= mis_d;
         to_q    <= to_d;
         cnt_q   <= cnt_d;
      end
   end

   assign mem_req    = req_q;
   assign mem_we     = we_q;
   assign mem_addr   = addr_q;
   assign mem_wdata  = wdata_q;
   assign ReadDataM  = rdata_q;
   assign misalign   = mis_q;
   assign timeout    = to_q;
   assign StallCount = cnt_q;

endmodule
